// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU (alu_seq).
//   op_e    : 4-bit operation codes driven on alu_seq.op (13-15 are illegal)
//   state_e : control FSM states of alu_seq
//   OP_W    : operation code width
package alu_pkg;

  localparam int unsigned OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_MUL   = 4'd4,
    OP_DIV   = 4'd5,
    OP_SHR   = 4'd6,
    OP_SHL   = 4'd7,
    OP_ROR   = 4'd8,
    OP_ROL   = 4'd9,
    OP_NEG   = 4'd10,
    OP_NOT   = 4'd11,
    OP_INCPC = 4'd12
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } state_e;

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative signed radix-2 Booth multiplier and restoring
// divider, plus the divide sign fix-up.
//   clk, clr      : clock, asynchronous active-high reset
//   start_i       : load operands (first iteration is performed on this edge)
//   div_i         : with start_i, selects divide instead of multiply
//   step_i        : perform one further iteration
//   a_i, b_i      : operands (multiplicand/dividend, multiplier/divisor)
//   last_o        : current step is the final iteration
//   mul_hi_o/lo_o : product as it will be after the current step
//   div_hi_o/lo_o : signed remainder / quotient from the settled registers
//   div_zero_o    : last loaded divide had a zero divisor
module alu_seq_muldiv #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start_i,
  input  logic             div_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             last_o,
  output logic [WIDTH-1:0] mul_hi_o,
  output logic [WIDTH-1:0] mul_lo_o,
  output logic [WIDTH-1:0] div_hi_o,
  output logic [WIDTH-1:0] div_lo_o,
  output logic             div_zero_o
);

  localparam int unsigned SHW = $clog2(WIDTH);
  // Iteration 1 happens on the start edge, so the WIDTH-th iteration is the
  // step taken while the counter reads WIDTH-2.
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 2);

  // Booth accumulator {A (WIDTH+1 bits), Q (WIDTH bits), q-1}; the extra A bit
  // keeps A +/- M from overflowing when M is the most negative value.
  function automatic logic [2*WIDTH+1:0] booth_step(input logic [2*WIDTH+1:0] p,
                                                    input logic [WIDTH:0]     m);
    logic [WIDTH:0] acc;
    acc = p[2*WIDTH+1:WIDTH+1];
    case (p[1:0])
      2'b01:   acc = acc + m;
      2'b10:   acc = acc - m;
      default: acc = acc;
    endcase
    return {acc[WIDTH], acc, p[WIDTH:1]};
  endfunction

  // One restoring step; returns {remainder, quotient}.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                  input logic [WIDTH-1:0] quo,
                                                  input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] sh;
    logic           ge;
    sh = {rem, quo[WIDTH-1]};
    ge = (sh >= {1'b0, dvs});
    return {(ge ? WIDTH'(sh - {1'b0, dvs}) : sh[WIDTH-1:0]), quo[WIDTH-2:0], ge};
  endfunction

  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH+1:0] p_q, p_d, p_step;
  logic [WIDTH:0]     m_q, m_d;
  logic [WIDTH-1:0]   rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic               negq_q, negq_d, negr_q, negr_d, dz_q, dz_d, div_q, div_d;
  logic [WIDTH-1:0]   a_mag, b_mag;

  assign a_mag  = a_i[WIDTH-1] ? -a_i : a_i;
  assign b_mag  = b_i[WIDTH-1] ? -b_i : b_i;
  assign p_step = booth_step(p_q, m_q);

  always_comb begin
    cnt_d  = cnt_q;
    p_d    = p_q;
    m_d    = m_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;
    dz_d   = dz_q;
    div_d  = div_q;
    if (start_i) begin
      cnt_d = '0;
      div_d = div_i;
      m_d   = {a_i[WIDTH-1], a_i};
      p_d   = booth_step({{(WIDTH+1){1'b0}}, b_i, 1'b0}, {a_i[WIDTH-1], a_i});
      dvs_d = b_mag;
      if (b_i == '0) begin
        // Zero divisor: preload so the fix-up yields hi=a, lo=all ones.
        dz_d   = 1'b1;
        rem_d  = a_i;
        quo_d  = '1;
        negq_d = 1'b0;
        negr_d = 1'b0;
      end else begin
        dz_d           = 1'b0;
        {rem_d, quo_d} = div_step('0, a_mag, b_mag);
        negq_d         = a_i[WIDTH-1] ^ b_i[WIDTH-1];
        negr_d         = a_i[WIDTH-1];
      end
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (div_q) {rem_d, quo_d} = div_step(rem_q, quo_q, dvs_q);
      else       p_d = p_step;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_q  <= '0;
      p_q    <= '0;
      m_q    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
      dz_q   <= 1'b0;
      div_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      m_q    <= m_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
      dz_q   <= dz_d;
      div_q  <= div_d;
    end
  end

  assign last_o     = step_i && (cnt_q == CNT_LAST);
  assign mul_hi_o   = p_step[2*WIDTH:WIDTH+1];
  assign mul_lo_o   = p_step[WIDTH:1];
  assign div_hi_o   = negr_q ? -rem_q : rem_q;
  assign div_lo_o   = negq_q ? -quo_q : quo_q;
  assign div_zero_o = dz_q;

endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential ALU with start/busy/done handshake.
// Single-cycle ops complete on the accepting edge; MUL takes WIDTH cycles,
// DIV WIDTH+1 (2 with a zero divisor) via alu_seq_muldiv.
//   clk, clr             : clock, asynchronous active-high reset
//   start, op, a, b      : request, op code (alu_pkg::op_e), operands
//   busy                 : MUL/DIV in progress; start ignored meanwhile
//   done                 : one-cycle pulse, results valid from this cycle
//   result_hi, result_lo : 2*WIDTH result, held until the next done
//   div_zero, illegal_op : status of the last completed op
// Build option ALU_SEQ_FLAGS_EN adds flag_z/flag_n/flag_c/flag_v.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned PC_INC = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] result_lo,
  output logic             div_zero,
  output logic             illegal_op
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
`endif
);

  localparam int unsigned SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             done_q, done_d, dz_q, dz_d, ill_q, ill_d;

  logic             md_start, md_div, md_step, md_last, md_dz;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;

  logic [SHW-1:0]   amt;
  logic [WIDTH-1:0] sum;

  assign amt = b[SHW-1:0];

`ifdef ALU_SEQ_FLAGS_EN
  logic [3:0] flags_q, flags_d;  // {z, n, c, v}
  logic       carry, c_new, v_new;
  logic [WIDTH:0] sum_ext;
  // SUB as a + ~b + 1 so the carry-out is the not-borrow.
  assign sum_ext = (op == OP_SUB) ? ({1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1))
                                  : ({1'b0, a} + {1'b0, b});
  assign sum   = sum_ext[WIDTH-1:0];
  assign carry = sum_ext[WIDTH];
`else
  assign sum = (op == OP_SUB) ? (a - b) : (a + b);
`endif

  alu_seq_muldiv #(
    .WIDTH(WIDTH)
  ) u_muldiv (
    .clk        (clk),
    .clr        (clr),
    .start_i    (md_start),
    .div_i      (md_div),
    .step_i     (md_step),
    .a_i        (a),
    .b_i        (b),
    .last_o     (md_last),
    .mul_hi_o   (mul_hi),
    .mul_lo_o   (mul_lo),
    .div_hi_o   (div_hi),
    .div_lo_o   (div_lo),
    .div_zero_o (md_dz)
  );

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    ill_d    = ill_q;
    md_start = 1'b0;
    md_div   = 1'b0;
    md_step  = 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
    flags_d  = flags_q;
    c_new    = 1'b0;
    v_new    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dz_d  = 1'b0;
          ill_d = 1'b0;
          case (op)
            OP_MUL: begin
              md_start = 1'b1;
              state_d  = ST_MUL;
            end
            OP_DIV: begin
              md_start = 1'b1;
              md_div   = 1'b1;
              state_d  = (b == '0) ? ST_FIX : ST_DIV;
            end
            default: begin
              done_d = 1'b1;
              hi_d   = '0;
              case (op)
                OP_AND:   lo_d = a & b;
                OP_OR:    lo_d = a | b;
                OP_ADD: begin
                  lo_d = sum;
                  hi_d = {WIDTH{sum[WIDTH-1]}};
`ifdef ALU_SEQ_FLAGS_EN
                  c_new = carry;
                  v_new = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`endif
                end
                OP_SUB: begin
                  lo_d = sum;
                  hi_d = {WIDTH{sum[WIDTH-1]}};
`ifdef ALU_SEQ_FLAGS_EN
                  c_new = carry;
                  v_new = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
`endif
                end
                OP_SHR:   lo_d = a >> amt;
                OP_SHL:   lo_d = a << amt;
                OP_ROR:   lo_d = WIDTH'({a, a} >> amt);
                OP_ROL:   lo_d = WIDTH'(({a, a} << amt) >> WIDTH);
                OP_NEG:   lo_d = -b;
                OP_NOT:   lo_d = ~b;
                OP_INCPC: lo_d = b + WIDTH'(PC_INC);
                default: begin
                  lo_d  = '0;
                  ill_d = 1'b1;
                end
              endcase
            end
          endcase
        end
      end
      ST_MUL: begin
        md_step = 1'b1;
        if (md_last) begin
          hi_d    = mul_hi;
          lo_d    = mul_lo;
          done_d  = 1'b1;
          state_d = ST_IDLE;
`ifdef ALU_SEQ_FLAGS_EN
          v_new = (mul_hi != {WIDTH{mul_lo[WIDTH-1]}});
`endif
        end
      end
      ST_DIV: begin
        md_step = 1'b1;
        if (md_last) state_d = ST_FIX;
      end
      ST_FIX: begin
        hi_d    = div_hi;
        lo_d    = div_lo;
        dz_d    = md_dz;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef ALU_SEQ_FLAGS_EN
    if (done_d) flags_d = {({hi_d, lo_d} == '0), hi_d[WIDTH-1], c_new, v_new};
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
`ifdef ALU_SEQ_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign result_hi  = hi_q;
  assign result_lo  = lo_q;
  assign div_zero   = dz_q;
  assign illegal_op = ill_q;
`ifdef ALU_SEQ_FLAGS_EN
  assign flag_z = flags_q[3];
  assign flag_n = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];
`endif

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero, illegal_op;
  logic [31:0] result_hi, result_lo;

  int checks   = 0;
  int failures = 0;
  int lat, bcnt, dcnt;

  alu_seq #(
    .WIDTH (32),
    .PC_INC(4)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .result_hi (result_hi),
    .result_lo (result_lo),
    .div_zero  (div_zero),
    .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request at the current time (always #1 after a rising edge),
  // let one edge accept it, then drop start.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Latency counts the accepting edge as 1; bcnt counts busy samples before done.
  task automatic wait_done(output int l, output int bc);
    l = 1; bc = 0;
    while (done !== 1'b1 && l < 100) begin
      if (busy === 1'b1) bc++;
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic run(input string tag, input logic [3:0] o, input logic [31:0] x,
                     input logic [31:0] y, input int exp_lat,
                     input logic [31:0] ehi, input logic [31:0] elo);
    int l, bc;
    issue(o, x, y);
    wait_done(l, bc);
    check({tag, "_lat"}, 64'(l), 64'(exp_lat));
    check({tag, "_res"}, {result_hi, result_lo}, {ehi, elo});
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    #1;
    check("rst_outs", {60'd0, busy, done, div_zero, illegal_op}, 64'd0);
    check("rst_res", {result_hi, result_lo}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    clr = 1'b0;

    // ADD overflow boundary, then result holds and done drops
    run("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 1, 32'hFFFF_FFFF, 32'h8000_0000);
    @(posedge clk); #1;
    check("done_pulse", {63'd0, done}, 64'd0);
    check("hold", {result_hi, result_lo}, 64'hFFFF_FFFF_8000_0000);

    // MUL -3*5
    issue(OP_MUL, 32'hFFFF_FFFD, 32'd5);
    wait_done(lat, bcnt);
    check("mul_lat", 64'(lat), 64'd32);
    check("mul_busy", 64'(bcnt), 64'd31);
    check("mul_res", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mul_busy_end", {63'd0, busy}, 64'd0);
    run("mul_min", OP_MUL, 32'h8000_0000, 32'h8000_0000, 32, 32'h4000_0000, 32'h0);

    // DIV signs and zero divisor
    run("div_n7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_7_n2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 33, 32'h1, 32'hFFFF_FFFD);
    run("div_min_n1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    check("div_nz_flag", {63'd0, div_zero}, 64'd0);
    run("div_zero", OP_DIV, 32'd100, 32'd0, 2, 32'd100, 32'hFFFF_FFFF);
    check("div_zero_flag", {63'd0, div_zero}, 64'd1);

    // rotates (amount masked to 5 bits)
    run("ror0", OP_ROR, 32'h1, 32'd0, 1, 32'h0, 32'h1);
    check("div_zero_clr", {63'd0, div_zero}, 64'd0);
    run("ror1", OP_ROR, 32'h1, 32'd1, 1, 32'h0, 32'h8000_0000);
    run("ror33", OP_ROR, 32'h1, 32'd33, 1, 32'h0, 32'h8000_0000);
    run("rol1", OP_ROL, 32'h8000_0000, 32'd1, 1, 32'h0, 32'h1);

    // remaining single-cycle ops
    run("sub", OP_SUB, 32'd5, 32'd7, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("shr", OP_SHR, 32'h8000_0000, 32'h24, 1, 32'h0, 32'h0800_0000);
    run("shl", OP_SHL, 32'h1, 32'd31, 1, 32'h0, 32'h8000_0000);
    run("and", OP_AND, 32'hF0F0_FF00, 32'h0FF0_F0F0, 1, 32'h0, 32'h00F0_F000);
    run("or", OP_OR, 32'hF0F0_FF00, 32'h0FF0_F0F0, 1, 32'h0, 32'hFFF0_FFF0);
    run("neg", OP_NEG, 32'h0, 32'h1, 1, 32'h0, 32'hFFFF_FFFF);
    run("not", OP_NOT, 32'h0, 32'h0F0F_0F0F, 1, 32'h0, 32'hF0F0_F0F0);
    run("incpc", OP_INCPC, 32'h0, 32'h100, 1, 32'h0, 32'h104);

    // MUL aborted by reset; start while busy ignored
    issue(OP_MUL, 32'd3, 32'd4);
    repeat (4) begin @(posedge clk); #1; end
    op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_ignore", {62'd0, busy, done}, 64'd2);
    repeat (3) begin @(posedge clk); #1; end
    clr = 1'b1;
    #1;
    check("abort_outs", {62'd0, busy, done}, 64'd0);
    check("abort_res", {result_hi, result_lo}, 64'd0);
    @(posedge clk); #1;
    clr = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcnt++;
    end
    check("abort_nodone", 64'(dcnt), 64'd0);
    check("abort_res2", {result_hi, result_lo}, 64'd0);
    run("add_after_rst", OP_ADD, 32'd2, 32'd2, 1, 32'h0, 32'd4);

    // back-to-back: ADD accepted in MUL's done cycle
    issue(OP_MUL, 32'd6, 32'd7);
    wait_done(lat, bcnt);
    check("b2b_mul_lat", 64'(lat), 64'd32);
    check("b2b_mul", {result_hi, result_lo}, 64'd42);
    issue(OP_ADD, 32'd10, 32'd20);
    check("b2b_add", {31'd0, done, result_hi, result_lo}, {31'd0, 1'b1, 64'd30});

    // illegal op
    run("illegal", 4'd14, 32'h1234, 32'h5678, 1, 32'h0, 32'h0);
    check("illegal_flag", {63'd0, illegal_op}, 64'd1);
    run("illegal_clr", OP_AND, 32'hFF, 32'h0F, 1, 32'h0, 32'h0F);
    check("illegal_flag_clr", {63'd0, illegal_op}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
